ula_timing: RTL

// - Timing source that sits directly upstream of the Z80 core wrapper.
// - Derives the CPU clock-enable pair (cep/cen) and the frame interrupt (mi) from the master clock.
// - Owns the 48K frame counters (T-states per line, lines per frame).
// - Stretches the CPU clock under ULA memory/IO contention so CPU timing matches a real 48K machine.
//

---
 rtl/ula_timing_if.sv | 23 ++
 rtl/ula_timing.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ula_timing_if.sv
// CPU-side bus and timing outputs of the 48K ULA timing source.
// The master modport is the timing source; the slave modport is the CPU/bus side.
interface ula_timing_if;
    logic [15:0] a;
    logic        mreq;
    logic        iorq;
    logic        rfsh;
    logic        cep;
    logic        cen;
    logic        mi;
    logic [8:0]  hcount;
    logic [8:0]  vcount;

    modport master (
        input  a, mreq, iorq, rfsh,
        output cep, cen, mi, hcount, vcount
    );

    modport slave (
        output a, mreq, iorq, rfsh,
        input  cep, cen, mi, hcount, vcount
    );
endinterface

// File: rtl/ula_timing.sv
// ula_timing: 48K frame timing source. Generates CPU clock enables (cep/cen),
// the frame interrupt (mi) and stretches the CPU clock under ULA contention.
// hcount counts half-T-states; vcount counts lines.
module ula_timing #(
    parameter int DIV        = 8,
    parameter int HTOTAL     = 448,
    parameter int VTOTAL     = 312,
    parameter int INT_LINE   = 248,
    parameter int INT_LEN    = 64,
    parameter int CONT_FIRST = 64,
    parameter int CONT_LAST  = 255,
    parameter int CONT_H     = 256
) (
    input  logic         clock,
    input  logic         reset,
    ula_timing_if.master bus
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PH_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [8:0]    H_LAST  = 9'(HTOTAL - 1);
    localparam logic [8:0]    V_LAST  = 9'(VTOTAL - 1);
    localparam logic [8:0]    I_LINE  = 9'(INT_LINE);
    localparam logic [8:0]    I_LEN   = 9'(INT_LEN);
    localparam logic [8:0]    C_FIRST = 9'(CONT_FIRST);
    localparam logic [8:0]    C_LAST  = 9'(CONT_LAST);
    localparam logic [8:0]    C_H     = 9'(CONT_H);

    // Contended bus cycle: memory access to bank 0x4000-0x7FFF, or an even-port IO access.
    function automatic logic contended_access(
        input logic [1:0] bank,
        input logic       a0,
        input logic       mreq_n,
        input logic       iorq_n,
        input logic       rfsh_n
    );
        logic mem_hit;
        logic io_hit;
        mem_hit = (bank == 2'b01) && ((mreq_n == 1'b0) || (rfsh_n == 1'b1));
        io_hit  = (iorq_n == 1'b0) && (a0 == 1'b0);
        return mem_hit || io_hit;
    endfunction

    logic [PW-1:0] phase_r;
    logic [8:0]    hcount_r;
    logic [8:0]    vcount_r;
    logic          stall_r;
    logic          cep_r;
    logic          cen_r;
    logic          mi_r;

    logic          h_tick_s;
    logic          h_wrap_s;
    logic [8:0]    hcount_next_s;
    logic [8:0]    vcount_next_s;
    logic          in_window_s;
    logic          stall_next_s;
    logic          mi_next_s;

    // Next-value logic for counters, contention window and interrupt.
    always_comb begin
        h_tick_s      = (phase_r == PH_ZERO) || (phase_r == PH_HALF);
        h_wrap_s      = (hcount_r == H_LAST);
        hcount_next_s = 9'd0;
        vcount_next_s = vcount_r;
        if (h_wrap_s) begin
            hcount_next_s = 9'd0;
            if (vcount_r == V_LAST) begin
                vcount_next_s = 9'd0;
            end else begin
                vcount_next_s = vcount_r + 9'd1;
            end
        end else begin
            hcount_next_s = hcount_r + 9'd1;
            vcount_next_s = vcount_r;
        end
        // The low three bits of the T-state index walk the 6,5,4,3,2,1,0,0 delay pattern;
        // only the first six positions of each 8-T-state group are stretched.
        in_window_s  = (vcount_r >= C_FIRST) && (vcount_r <= C_LAST) &&
                       (hcount_r < C_H) && (hcount_r[3:1] < 3'd6);
        stall_next_s = in_window_s &&
                       contended_access(bus.a[15:14], bus.a[0], bus.mreq, bus.iorq, bus.rfsh);
        mi_next_s    = !((vcount_r == I_LINE) && (hcount_r < I_LEN));
    end

    // Free-running phase counter; never stalled so the frame timing stays exact.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_r <= PH_ZERO;
        end else if (phase_r == PH_LAST) begin
            phase_r <= PH_ZERO;
        end else begin
            phase_r <= phase_r + PH_ONE;
        end
    end

    // Frame counters: hcount steps twice per T-state, vcount steps on hcount wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hcount_r <= 9'd0;
            vcount_r <= 9'd0;
        end else if (h_tick_s) begin
            hcount_r <= hcount_next_s;
            vcount_r <= vcount_next_s;
        end else begin
            hcount_r <= hcount_r;
            vcount_r <= vcount_r;
        end
    end

    // Stall decision taken on the last phase and held for the whole next T-state,
    // so cep and cen of that T-state are always suppressed together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_r <= 1'b0;
        end else if (phase_r == PH_LAST) begin
            stall_r <= stall_next_s;
        end else begin
            stall_r <= stall_r;
        end
    end

    // Registered clock-enable pulses and frame interrupt.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cep_r <= 1'b0;
            cen_r <= 1'b0;
            mi_r  <= 1'b1;
        end else begin
            cep_r <= (phase_r == PH_ZERO) && !stall_r;
            cen_r <= (phase_r == PH_HALF) && !stall_r;
            mi_r  <= mi_next_s;
        end
    end

    assign bus.cep    = cep_r;
    assign bus.cen    = cen_r;
    assign bus.mi     = mi_r;
    assign bus.hcount = hcount_r;
    assign bus.vcount = vcount_r;
endmodule
